sequence_generator: RTL
=======================

Name: sequence_generator

Overview:
Serial pattern transmitter and the source end of the serial-bit sequence detectors in this design. On a start request it captures a WIDTH-bit pattern and a repeat count. It then drives the pattern MSB-first on a single serial line, one bit per clock, repeating it back-to-back. Used as the stimulus and transmit side for the Moore detector path, for example to send 1011 framed so the detector fires.

Parameters:
WIDTH, 4, pattern length in bits (>= 2)
CNT_W, 4, width of repeat count; max repeats = 2^CNT_W - 1

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request to begin transmission; sampled only in IDLE
pattern  input  WIDTH  bit pattern to send, MSB transmitted first
repeat_n  input  CNT_W  number of times to send the pattern back-to-back
out  output  1  serial data bit (registered)
valid  output  1  high in every cycle where out carries a pattern bit
busy  output  1  high from first bit through DONE state
done  output  1  single-cycle pulse after the last bit

Behaviour:
- Reset: asynchronous, active-high. Forces state IDLE, out=0, valid=0, busy=0, done=0. Clears the shift register, bit counter and repeat counter. Takes effect immediately, including mid-transmission; the partial stream is abandoned.
- The block is a Moore FSM: all outputs are decoded from registered state and datapath only, with no combinational path from inputs to outputs.
- State IDLE: out=0, valid=0, busy=0, done=0.
  - If start=1 and repeat_n!=0: capture pattern into the hold register and the shift register, load rep_cnt=repeat_n, bit_cnt=0, then go to SEND.
  - If start=1 and repeat_n==0: go to DONE; no bits are sent.
  - Otherwise stay in IDLE.
- State SEND: out=shreg[WIDTH-1], valid=1, busy=1. Each cycle, shreg shifts left (LSB filled with 0) and bit_cnt increments.
  - When bit_cnt==WIDTH-1 (last bit of the current repetition):
    - If rep_cnt>1: decrement rep_cnt, reload shreg from the hold register, set bit_cnt=0, stay in SEND. There is no gap cycle between repetitions.
    - If rep_cnt==1: go to DONE.
- State DONE: out=0, valid=0, busy=1, done=1 for exactly one cycle, then go to IDLE unconditionally. start is ignored in DONE.
- Latency: start is sampled high at edge k; the first bit appears on out after edge k. The last bit is on out for the cycle after edge k+WIDTH*repeat_n-1. done is high in the following cycle.
- Total valid cycles per request = WIDTH*repeat_n.
- Input isolation:
  - start is ignored while busy.
  - Changes to pattern or repeat_n after capture have no effect on the transmission in progress.
- Width rules:
  - bit_cnt is ceil(log2(WIDTH)) bits wide and wraps only through the explicit reset to 0.
  - rep_cnt is CNT_W bits wide; it never decrements below 1 in SEND.
- Encoding: illegal or unused state encodings return to IDLE on the next edge with all outputs deasserted.

Test Plan:
- Single send: pattern=4'b1011, repeat_n=1, pulse start.
  - Required: out=1,0,1,1 with valid=1 for 4 cycles, then done=1 for 1 cycle, then IDLE.
  - Loopback: the detector's out rises exactly one cycle after the 4th bit.
- Repeat send: pattern=4'b1011, repeat_n=3.
  - Required: 12 contiguous valid bits, 101110111011, with no gap.
  - Required: done one cycle after bit 12; busy high for 13 cycles.
- Zero repeat: repeat_n=0, start.
  - Required: valid never asserts, out stays 0; done=1 in the cycle after the start edge, then IDLE.
- Input isolation: during SEND, pulse start and change pattern to 4'b0000 and repeat_n to 5.
  - Required: the original 1011 stream completes unchanged and no second transmission begins.
  - Then a start in IDLE with the new inputs: required, 20 zero bits with valid=1.
- Reset mid-operation: assert rst asynchronously (between edges) during bit 2 of repetition 2 of 4.
  - Required: out, valid, busy and done drop to 0 immediately, without waiting for a clock edge.
  - After rst deasserts: state is IDLE, and a new start transmits from the pattern MSB.
- Max count: repeat_n=4'hF, pattern=4'b1000.
  - Required: 60 valid bits, with 1 followed by three 0s repeated 15 times.
  - Required: done pulses exactly once.

Source files
------------

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a captured WIDTH-bit pattern MSB-first,
// repeat_n times back-to-back, then pulses done for one cycle.
module sequence_generator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg_o
);

    localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] hold_q,    hold_d;
    logic [WIDTH-1:0] shreg_q,   shreg_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;

    // Request/stream contract: start is a level sampled only in IDLE on a
    // rising edge; pattern and repeat_n are captured on that same edge.
    // out carries a pattern bit exactly in the cycles where valid is high;
    // there is no back-pressure, the stream runs at one bit per clock.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (repeat_n != '0) begin
                        hold_d    = pattern;
                        shreg_d   = pattern;
                        rep_cnt_d = repeat_n;
                        bit_cnt_d = '0;
                        state_d   = ST_SEND;
                    end else begin
                        state_d   = ST_DONE;
                    end
                end
            end

            ST_SEND: begin
                if (bit_cnt_q == LAST_BIT) begin
                    if (rep_cnt_q > ONE_REP) begin
                        // Reload straight from the hold copy: no gap cycle.
                        rep_cnt_d = rep_cnt_q - ONE_REP;
                        shreg_d   = hold_q;
                        bit_cnt_d = '0;
                    end else begin
                        shreg_d   = '0;
                        bit_cnt_d = '0;
                        state_d   = ST_DONE;
                    end
                end else begin
                    shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                hold_d    = '0;
                shreg_d   = '0;
                bit_cnt_d = '0;
                rep_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    // Outputs decode only flops, so reset clears them without a clock edge.
    always_comb begin
        out   = 1'b0;
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            ST_SEND: begin
                out   = shreg_q[WIDTH-1];
                valid = 1'b1;
                busy  = 1'b1;
            end
            ST_DONE: begin
                busy  = 1'b1;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_dbg_o = state_q;

endmodule
